// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 scan-code decoder.
// The decoder's optional ASCII feature is selected by the PS2_ASCII_EN macro.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [7:0] ascii;
   } key_event_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;
   localparam logic [7:0] LSHIFT     = 8'h12;
   localparam logic [7:0] RSHIFT     = 8'h59;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte input and key-event output bundle of the PS/2 scan-code decoder.
// master = receiver/consumer side, slave = decoder side.
interface ps2_scancode_decoder_if;
   logic [7:0] scan_code;
   logic       scan_ready;
   logic       ev_ready;
   logic       clr_flags;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic [7:0] ev_ascii;
   logic       overflow;
   logic       err;

   modport master (
      output scan_code, scan_ready, ev_ready, clr_flags,
      input  ev_valid, ev_code, ev_ext, ev_break, ev_ascii, overflow, err
   );

   modport slave (
      input  scan_code, scan_ready, ev_ready, clr_flags,
      output ev_valid, ev_code, ev_ext, ev_break, ev_ascii, overflow, err
   );
endinterface

// File: rtl/ps2_event_fifo.sv
// Key-event FIFO; pointers carry one extra wrap bit so full and empty are distinct.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  key_event_t i_wdata,
   input  logic       i_pop,
   output key_event_t o_rdata,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   key_event_t  r_mem [DEPTH];
   logic        w_wr_en;
   logic        w_rd_en;

   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign w_rd_en = i_pop & ~o_empty;
   assign w_wr_en = i_push & (~o_full | w_rd_en);

   // storage array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   // read/write pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // head entry, zero while empty
   always_comb begin
      if (o_empty) begin
         o_rdata = '0;
      end else begin
         o_rdata = r_mem[r_rd_ptr[AW-1:0]];
      end
   end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 decoder: strips E0/F0/E1 prefixes into one key event per keystroke.
// Define PS2_ASCII_EN to add shift tracking and ASCII lookup; otherwise ev_ascii is 0.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int PAUSE_SKIP = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   ps2_scancode_decoder_if.slave  bus
);
   localparam int CW = $clog2(PAUSE_SKIP + 1);

   logic          r_scan_q;
   logic          r_armed;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_overflow;
   logic          r_err;
   logic          w_stb;
   logic          w_push;
   logic          w_pop;
   logic          w_err_set;
   logic          w_full;
   logic          w_empty;
   key_event_t    w_ev;
   key_event_t    w_head;

`ifdef PS2_ASCII_EN
   logic r_shift_l;
   logic r_shift_r;

   function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic shift);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      if (shift && (a >= 8'h61) && (a <= 8'h7A)) begin
         return a - 8'h20;
      end else begin
         return a;
      end
   endfunction
`endif

   // armed stays low for the first clock so a level already high at reset release is not a byte
   assign w_stb = r_armed & bus.scan_ready & ~r_scan_q;
   assign w_pop = bus.ev_ready & ~w_empty;

   // byte edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan_q <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_scan_q <= bus.scan_ready;
         r_armed  <= 1'b1;
      end
   end

   // decoder state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // prefix decoding and event generation
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_push      = 1'b0;
      w_err_set   = 1'b0;
      w_ev.code   = bus.scan_code;
      w_ev.ext    = 1'b0;
      w_ev.brk    = 1'b0;
      w_ev.ascii  = 8'h00;
      if (w_stb) begin
         if ((bus.scan_code == PS2_ERR0) || (bus.scan_code == PS2_ERR1)) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.scan_code == PS2_EXT) begin
                     w_state_nxt = ST_EXT;
                  end else if (bus.scan_code == PS2_BRK) begin
                     w_state_nxt = ST_BRK;
                  end else if (bus.scan_code == PS2_PAUSE) begin
                     w_state_nxt = ST_PAUSE;
                     w_cnt_nxt   = '0;
                  end else if ((bus.scan_code == PS2_BAT) || (bus.scan_code == PS2_ACK) ||
                               (bus.scan_code == PS2_ECHO) || (bus.scan_code == PS2_RESEND)) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_push = 1'b1;
                  end
               end
               ST_EXT: begin
                  if (bus.scan_code == PS2_BRK) begin
                     w_state_nxt = ST_EXT_BRK;
                  end else if (bus.scan_code == PS2_EXT) begin
                     w_state_nxt = ST_EXT;
                  end else if (bus.scan_code == LSHIFT) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_push      = 1'b1;
                     w_ev.ext    = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_BRK: begin
                  w_push      = 1'b1;
                  w_ev.brk    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
               ST_EXT_BRK: begin
                  if (bus.scan_code == LSHIFT) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_push      = 1'b1;
                     w_ev.ext    = 1'b1;
                     w_ev.brk    = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_PAUSE: begin
                  // the last skipped byte completes the Pause sequence
                  if (r_cnt == CW'(PAUSE_SKIP - 1)) begin
                     w_push      = 1'b1;
                     w_ev.code   = PS2_PAUSE;
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + CW'(1);
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            endcase
         end
      end else begin
         w_state_nxt = r_state;
      end
`ifdef PS2_ASCII_EN
      w_ev.ascii = ascii_of(w_ev.code, r_shift_l | r_shift_r);
`endif
   end

`ifdef PS2_ASCII_EN
   // shift state follows non-extended shift make/break events
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift_l <= 1'b0;
         r_shift_r <= 1'b0;
      end else if (w_push && !w_ev.ext) begin
         if (w_ev.code == LSHIFT) r_shift_l <= ~w_ev.brk;
         if (w_ev.code == RSHIFT) r_shift_r <= ~w_ev.brk;
      end
   end
`endif

   // sticky flags; a set in the same cycle as clr_flags wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_overflow <= (w_push & w_full & ~w_pop) | (r_overflow & ~bus.clr_flags);
         r_err      <= w_err_set | (r_err & ~bus.clr_flags);
      end
   end

   ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_wdata (w_ev),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.ev_valid = ~w_empty;
   assign bus.ev_code  = w_head.code;
   assign bus.ev_ext   = w_head.ext;
   assign bus.ev_break = w_head.brk;
   assign bus.ev_ascii = w_head.ascii;
   assign bus.overflow = r_overflow;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: byte-sequence table plus corner-case sequences,
// with expected events queued at drive time and compared as the consumer pops them.
module tb_ps2_scancode_decoder;
`ifdef PS2_ASCII_EN
   localparam bit ASCII_EN = 1'b1;
`else
   localparam bit ASCII_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  nb;
      logic [1:0]  ne;
      logic [35:0] evs;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_err = 0;
   int          n_chk = 0;
   logic [17:0] exp_q [$];
   logic [17:0] mon_e;
   vec_t        tbl [10];

   always #5 clk = ~clk;

   ps2_scancode_decoder_if bus ();

   ps2_scancode_decoder #(.DEPTH(4), .PAUSE_SKIP(7)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] ev(input logic [7:0] c, input logic e, input logic b,
                                      input logic [7:0] a);
      return {c, e, b, (ASCII_EN ? a : 8'h00)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.scan_code  = b;
      bus.scan_ready = 1'b1;
      tick();
      bus.scan_ready = 1'b0;
      tick();
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         tick();
         k++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // scoreboard: every accepted event is compared against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.ev_valid && bus.ev_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_event: got %0h expected none",
                     {bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_ascii});
         end else begin
            mon_e = exp_q.pop_front();
            chk("event", {14'd0, bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_ascii},
                {14'd0, mon_e});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{bytes: 64'h1C,             nb: 4'd1, ne: 2'd1, evs: {18'd0, ev(8'h1C, 1'b0, 1'b0, 8'h61)}};
      tbl[1] = '{bytes: 64'h1C_F0,          nb: 4'd2, ne: 2'd1, evs: {18'd0, ev(8'h1C, 1'b0, 1'b1, 8'h61)}};
      tbl[2] = '{bytes: 64'h75_F0_E0_75_E0, nb: 4'd5, ne: 2'd2,
                 evs: {ev(8'h75, 1'b1, 1'b1, 8'h00), ev(8'h75, 1'b1, 1'b0, 8'h00)}};
      tbl[3] = '{bytes: 64'h12_E0,          nb: 4'd2, ne: 2'd0, evs: 36'd0};
      tbl[4] = '{bytes: 64'h77_F0_14_F0_E1_77_14_E1, nb: 4'd8, ne: 2'd1,
                 evs: {18'd0, ev(8'hE1, 1'b0, 1'b0, 8'h00)}};
      tbl[5] = '{bytes: 64'h1C,             nb: 4'd1, ne: 2'd1, evs: {18'd0, ev(8'h1C, 1'b0, 1'b0, 8'h61)}};
      tbl[6] = '{bytes: 64'h2B_FA_AA,       nb: 4'd3, ne: 2'd1, evs: {18'd0, ev(8'h2B, 1'b0, 1'b0, 8'h66)}};
      tbl[7] = '{bytes: 64'h74_12_F0_E0_E0, nb: 4'd5, ne: 2'd1, evs: {18'd0, ev(8'h74, 1'b0, 1'b0, 8'h00)}};
      tbl[8] = '{bytes: 64'h29_FE_EE,       nb: 4'd3, ne: 2'd1, evs: {18'd0, ev(8'h29, 1'b0, 1'b0, 8'h20)}};
      tbl[9] = '{bytes: 64'h16_45,          nb: 4'd2, ne: 2'd2,
                 evs: {ev(8'h16, 1'b0, 1'b0, 8'h31), ev(8'h45, 1'b0, 1'b0, 8'h30)}};

      // reset with scan_ready already high
      bus.scan_code  = 8'h1C;
      bus.scan_ready = 1'b1;
      bus.ev_ready   = 1'b0;
      bus.clr_flags  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", bus.ev_valid, 0);
      chk("rst_code", bus.ev_code, 0);
      chk("rst_ext_brk", {bus.ev_ext, bus.ev_break}, 0);
      chk("rst_ascii", bus.ev_ascii, 0);
      chk("rst_flags", {bus.overflow, bus.err}, 0);
      rst_n = 1'b1;
      repeat (4) tick();
      chk("rst_level_not_byte", bus.ev_valid, 0);
      bus.scan_ready = 1'b0;
      tick();

      bus.ev_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < int'(tbl[i].ne); k++) exp_q.push_back(tbl[i].evs[18*k +: 18]);
         for (int j = 0; j < int'(tbl[i].nb); j++) send(tbl[i].bytes[8*j +: 8]);
         drain($sformatf("table_row%0d", i));
      end

      // latency and hold while stalled
      bus.ev_ready   = 1'b0;
      bus.scan_code  = 8'h1C;
      bus.scan_ready = 1'b1;
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 8'h61));
      chk("pre_strobe_valid", bus.ev_valid, 0);
      tick();
      chk("latency_valid", bus.ev_valid, 1);
      bus.scan_ready = 1'b0;
      repeat (3) tick();
      chk("hold_code", bus.ev_code, 32'h1C);
      bus.ev_ready = 1'b1;
      drain("latency_drain");

      // overflow with five keys into four slots
      bus.ev_ready = 1'b0;
      exp_q.push_back(ev(8'h15, 1'b0, 1'b0, 8'h71)); send(8'h15);
      exp_q.push_back(ev(8'h1D, 1'b0, 1'b0, 8'h77)); send(8'h1D);
      exp_q.push_back(ev(8'h24, 1'b0, 1'b0, 8'h65)); send(8'h24);
      exp_q.push_back(ev(8'h2D, 1'b0, 1'b0, 8'h72)); send(8'h2D);
      chk("no_ovf_at_full", bus.overflow, 0);
      send(8'h2C);
      chk("overflow_set", bus.overflow, 1);
      chk("head_kept", bus.ev_code, 32'h15);
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      chk("overflow_clr", bus.overflow, 0);

      // pop and push together while full
      bus.scan_code  = 8'h35;
      bus.scan_ready = 1'b1;
      bus.ev_ready   = 1'b1;
      exp_q.push_back(ev(8'h35, 1'b0, 1'b0, 8'h79));
      tick();
      bus.ev_ready   = 1'b0;
      bus.scan_ready = 1'b0;
      tick();
      chk("full_poppush_no_ovf", bus.overflow, 0);
      chk("full_poppush_head", bus.ev_code, 32'h1D);
      bus.ev_ready = 1'b1;
      drain("full_poppush_order");

      // FF in the middle of a break returns to IDLE
      send(8'hF0);
      send(8'hFF);
      chk("err_set", bus.err, 1);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 8'h61));
      send(8'h1C);
      drain("after_err");
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      chk("err_clr", bus.err, 0);
      bus.scan_code  = 8'h00;
      bus.scan_ready = 1'b1;
      bus.clr_flags  = 1'b1;
      tick();
      bus.scan_ready = 1'b0;
      bus.clr_flags  = 1'b0;
      tick();
      chk("err_set_wins_clr", bus.err, 1);

      // reset between E0 and its code
      send(8'hE0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid_flags", {bus.overflow, bus.err}, 0);
      exp_q.push_back(ev(8'h75, 1'b0, 1'b0, 8'h00));
      send(8'h75);
      drain("rst_mid_ext");

      // shift-held ASCII sequence
      exp_q.push_back(ev(8'h12, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 8'h41));
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b1, 8'h41));
      exp_q.push_back(ev(8'h12, 1'b0, 1'b1, 8'h00));
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 8'h61));
      send(8'h12);
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
      send(8'hF0);
      send(8'h12);
      send(8'h1C);
      drain("shift_ascii");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
